const_loader_ctrl: RTL and testbench

- Sequencer that materialises an arbitrary 64-bit constant into a destination register using the shared immediate sign extender in MOVZ/MOVK mode (Ctrl = 3'b100).
- For each 16-bit halfword it drives the extender's Imm32/Ctrl inputs and merges the returned BusImm into an accumulator. It then issues a single register-file write.
- It sits between the decode/constant-pool path and the register-file write port.

---
 rtl/const_loader_ctrl.sv | 156 +++++++++++++++
 tb/tb_const_loader_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/const_loader_ctrl.sv
// Materialises a 64-bit constant through the shared immediate extender (MOVZ/MOVK path).
// The result is merged halfword by halfword and then written to the register file in one write.
module const_loader_ctrl #(
    parameter logic [2:0] CTRL_MZ   = 3'b100,
    parameter bit         SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [63:0] ReqConst,
    input  logic [4:0]  ReqRd,
    output logic [31:0] ExtImm32,
    output logic [2:0]  ExtCtrl,
    input  logic [63:0] ExtBusImm,
    output logic        RegWr,
    output logic [4:0]  RegW,
    output logic [63:0] RegData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [1:0]  DbgState
);

    // ReqValid/ReqReady: a request transfers on a rising edge where both are high;
    // ReqReady is high only in IDLE, and inputs are ignored on every other edge.

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] const_q, const_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  mask_q, mask_d;
    logic [63:0] acc_q, acc_d;
    logic        err_q, err_d;
    logic        first_q, first_d;

    logic [1:0]  lane_k;
    logic [15:0] hw_chunk;
    logic [63:0] lane_bits;
    logic        lane_viol;
    logic [3:0]  mask_clr;

    // A zero constant still needs one MOVZ so the destination gets written with zero.
    function automatic logic [3:0] issue_mask(input logic [63:0] c);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = (c[16*k +: 16] != 16'h0) || !SKIP_ZERO;
        end
        if (c == 64'h0) begin
            m = 4'b0001;
        end
        return m;
    endfunction

    always_comb begin
        lane_k = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k]) begin
                lane_k = k[1:0];
            end
        end
        hw_chunk  = const_q[{lane_k, 4'b0000} +: 16];
        lane_bits = 64'hFFFF << {lane_k, 4'b0000};
        lane_viol = |(ExtBusImm & ~lane_bits);
        mask_clr  = mask_q & ~(4'b0001 << lane_k);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            const_q <= 64'h0;
            rd_q    <= 5'd0;
            mask_q  <= 4'b0000;
            acc_q   <= 64'h0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            const_q <= const_d;
            rd_q    <= rd_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        const_d  = const_q;
        rd_d     = rd_q;
        mask_d   = mask_q;
        acc_d    = acc_q;
        err_d    = err_q;
        first_d  = first_q;
        ReqReady = 1'b0;
        ExtCtrl  = 3'b000;
        ExtImm32 = 32'h0;
        RegWr    = 1'b0;
        Done     = 1'b0;
        Busy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    const_d = ReqConst;
                    rd_d    = ReqRd;
                    acc_d   = 64'h0;
                    err_d   = 1'b0;
                    mask_d  = issue_mask(ReqConst);
                    first_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                Busy     = 1'b1;
                ExtCtrl  = CTRL_MZ;
                ExtImm32 = {(first_q ? OPC_MOVZ : OPC_MOVK), lane_k, hw_chunk, rd_q};
                // Only the extender result feeds the accumulator, so a broken extender shows up in RegData.
                acc_d    = acc_q | ExtBusImm;
                if (lane_viol) begin
                    err_d = 1'b1;
                end
                mask_d  = mask_clr;
                first_d = 1'b0;
                if (mask_clr == 4'b0000) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                Busy    = 1'b1;
                RegWr   = 1'b1;
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign RegW     = rd_q;
    assign RegData  = acc_q;
    assign Err      = err_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_const_loader_ctrl.sv
// Bench for const_loader_ctrl: directed vector table, hand-written corner sequences and
// random loads checked against a halfword-level model with a behavioural extender.
module tb_const_loader_ctrl;

    localparam logic [2:0] CTRL_MZ  = 3'b100;
    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic [63:0] ReqConst = 64'h0;
    logic [4:0]  ReqRd = 5'd0;
    logic [63:0] ExtBusImm;
    logic        ReqReady, RegWr, Busy, Done, Err;
    logic [31:0] ExtImm32;
    logic [2:0]  ExtCtrl;
    logic [4:0]  RegW;
    logic [63:0] RegData;
    logic [1:0]  DbgState;

    logic        faulty = 1'b0;
    int          total = 0;
    int          passed = 0;
    int          regwr_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [63:0] c;
        logic [4:0]  rd;
        bit          flt;
        int          n_issue;
        logic [63:0] data;
        bit          err;
    } vec_t;
    vec_t vecs[6];

    const_loader_ctrl dut (
        .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqConst(ReqConst), .ReqRd(ReqRd), .ExtImm32(ExtImm32), .ExtCtrl(ExtCtrl),
        .ExtBusImm(ExtBusImm), .RegWr(RegWr), .RegW(RegW), .RegData(RegData),
        .Busy(Busy), .Done(Done), .Err(Err), .DbgState(DbgState)
    );

    // Clock and behavioural extender (MOVZ/MOVK: place imm16 at halfword hw)
    always #5 CLK = ~CLK;

    always_comb begin
        if (faulty) ExtBusImm = 64'h1;
        else if (ExtCtrl == CTRL_MZ) ExtBusImm = {48'h0, ExtImm32[20:5]} << {ExtImm32[22:21], 4'b0000};
        else ExtBusImm = 64'h0;
    end

    always @(negedge CLK) if (RegWr === 1'b1) regwr_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Reference model: one issue word per nonzero halfword, ascending; zero constant -> one MOVZ of 0.
    task automatic model_issues(input logic [63:0] c, input logic [4:0] rd,
                                output int n_issue, output bit err_exp);
        logic [15:0] hw;
        bit first;
        first = 1'b1;
        err_exp = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            hw = c[16*k +: 16];
            if (hw != 16'h0) begin
                exp_q.push_back({(first ? OPC_MOVZ : OPC_MOVK), 2'(k), hw, rd});
                first = 1'b0;
                if (faulty && k != 0) err_exp = 1'b1;
            end
        end
        if (exp_q.size() == 0) exp_q.push_back({OPC_MOVZ, 2'd0, 16'h0, rd});
        n_issue = exp_q.size();
    endtask

    // Driver: waits (bounded) for ReqReady at a negedge, transfers on the next posedge,
    // then scrambles the request inputs to show they are ignored mid-sequence.
    task automatic accept_req(input logic [63:0] c, input logic [4:0] rd);
        int waited;
        waited = 0;
        while (ReqReady !== 1'b1 && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        check("ready_before_accept", 64'(ReqReady), 64'd1);
        ReqValid = 1'b1;
        ReqConst = c;
        ReqRd    = rd;
        @(posedge CLK);
        @(negedge CLK);
        ReqValid = 1'b0;
        ReqConst = {$urandom, $urandom};
        ReqRd    = 5'($urandom);
    endtask

    // Called at the negedge of the first ISSUE cycle; returns at the negedge of the WRITE cycle.
    task automatic check_seq(input logic [63:0] c, input logic [4:0] rd, input int n_exp,
                             input logic [63:0] data_exp, input bit err_exp);
        int n_seen, n_dummy;
        bit e_dummy;
        logic [31:0] w;
        n_seen = 0;
        model_issues(c, rd, n_dummy, e_dummy);
        while (ExtCtrl === CTRL_MZ && n_seen < 6) begin
            if (exp_q.size() == 0) begin
                check("extra_issue", 64'(ExtImm32), 64'h0);
            end else begin
                w = exp_q.pop_front();
                check("issue_word", 64'(ExtImm32), 64'(w));
            end
            check("issue_busy_ready_wr", 64'({Busy, ReqReady, RegWr}), 64'(3'b100));
            n_seen++;
            @(negedge CLK);
        end
        check("issue_count", 64'(n_seen), 64'(n_exp));
        check("write_strobes", 64'({RegWr, Done, Busy, ReqReady}), 64'(4'b1110));
        check("write_addr", 64'(RegW), 64'(rd));
        check("write_data", RegData, data_exp);
        check("err_flag", 64'(Err), 64'(err_exp));
        exp_q.delete();
    endtask

    initial begin
        int base, n;
        bit e;
        logic [63:0] c;
        logic [4:0] rd;

        vecs[0] = '{64'h0000_0000_0000_1234, 5'd3,  1'b0, 1, 64'h0000_0000_0000_1234, 1'b0};
        vecs[1] = '{64'hDEAD_0000_BEEF_0000, 5'd9,  1'b0, 2, 64'hDEAD_0000_BEEF_0000, 1'b0};
        vecs[2] = '{64'h0,                   5'd31, 1'b0, 1, 64'h0,                   1'b0};
        vecs[3] = '{64'h1111_2222_3333_4444, 5'd1,  1'b0, 4, 64'h1111_2222_3333_4444, 1'b0};
        vecs[4] = '{64'h5,                   5'd7,  1'b0, 1, 64'h5,                   1'b0};
        vecs[5] = '{64'hABCD_0000_0000_0000, 5'd12, 1'b1, 1, 64'h1,                   1'b1};

        // Asynchronous reset before any clock edge
        #2 Reset = 1'b1;
        #1;
        check("rst_ready", 64'(ReqReady), 64'd1);
        check("rst_busy_wr_done_err", 64'({Busy, RegWr, Done, Err}), 64'd0);
        check("rst_ext", 64'({ExtCtrl, ExtImm32}), 64'd0);
        check("rst_regw", 64'(RegW), 64'd0);
        check("rst_regdata", RegData, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            faulty = vecs[i].flt;
            accept_req(vecs[i].c, vecs[i].rd);
            check_seq(vecs[i].c, vecs[i].rd, vecs[i].n_issue, vecs[i].data, vecs[i].err);
            @(negedge CLK);
            check("ready_after_write", 64'({ReqReady, Busy, RegWr}), 64'(3'b100));
            check("err_sticky_idle", 64'(Err), 64'(vecs[i].err));
        end

        // Err survives idle cycles and clears on the next accept
        faulty = 1'b0;
        repeat (2) @(negedge CLK);
        check("err_held", 64'(Err), 64'd1);
        accept_req(64'h42, 5'd4);
        check("err_cleared_on_accept", 64'(Err), 64'd0);
        check_seq(64'h42, 5'd4, 1, 64'h42, 1'b0);

        // Back-to-back: request held from the WRITE cycle is taken on the following edge only
        accept_req(64'h1111_2222_3333_4444, 5'd1);
        check_seq(64'h1111_2222_3333_4444, 5'd1, 4, 64'h1111_2222_3333_4444, 1'b0);
        ReqValid = 1'b1;
        ReqConst = 64'h5;
        ReqRd    = 5'd7;
        @(negedge CLK);
        check("b2b_idle_after_write", 64'({ReqReady, Busy, RegWr}), 64'(3'b100));
        @(posedge CLK);
        @(negedge CLK);
        ReqValid = 1'b0;
        ReqConst = {$urandom, $urandom};
        check_seq(64'h5, 5'd7, 1, 64'h5, 1'b0);

        // Reset during the second ISSUE cycle aborts without any write
        @(negedge CLK);
        base = regwr_cnt;
        accept_req(64'h1111_2222_3333_4444, 5'd2);
        @(negedge CLK);
        check("second_issue_active", 64'(ExtCtrl), 64'(CTRL_MZ));
        #1 Reset = 1'b1;
        #1;
        check("abort_ready_busy_err", 64'({ReqReady, Busy, Err}), 64'(3'b100));
        check("abort_wr_done_ctrl", 64'({RegWr, Done, ExtCtrl}), 64'd0);
        check("abort_regdata", RegData, 64'd0);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        repeat (6) @(negedge CLK);
        check("abort_no_regwr", 64'(regwr_cnt), 64'(base));

        // Random loads against the model
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < 4; k++) begin
                c[16*k +: 16] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            end
            rd = 5'($urandom);
            faulty = ($urandom_range(0, 9) == 0);
            model_issues(c, rd, n, e);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            accept_req(c, rd);
            check_seq(c, rd, n, faulty ? 64'h1 : c, e);
        end
        faulty = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its end within 500000 time units");
        $fatal(1);
    end

endmodule
